// File: rtl/cv32e40p_obi_pkg.sv
// Shared types and constants for the data-side OBI responder.
package cv32e40p_obi_pkg;

   localparam int unsigned OBI_DATA_WIDTH = 32;
   localparam int unsigned OBI_BE_WIDTH   = 4;
   localparam int unsigned MAX_RESP_LAT   = 8;

   // Right-shifting Fibonacci form of taps 16,14,13,11: feedback from bits 0,2,3,5.
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   typedef struct packed {
      logic [OBI_DATA_WIDTH-1:0] rdata;
      logic                      err;
   } obi_resp_t;

endpackage

// File: rtl/cv32e40p_obi_resp_delay.sv
// RESP_LAT-stage shift register carrying a valid flag and its response payload.
module cv32e40p_obi_resp_delay
   import cv32e40p_obi_pkg::*;
#(
   parameter int unsigned RESP_LAT = 1
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      in_valid_i,
   input  obi_resp_t in_resp_i,
   output logic      out_valid_o,
   output obi_resp_t out_resp_o
);

   logic [RESP_LAT-1:0] valid_q;
   obi_resp_t           resp_q [RESP_LAT];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
         for (int i = 0; i < RESP_LAT; i++) begin
            resp_q[i] <= '0;
         end
      end else begin
         valid_q[0] <= in_valid_i;
         resp_q[0]  <= in_resp_i;
         for (int i = 1; i < RESP_LAT; i++) begin
            valid_q[i] <= valid_q[i-1];
            resp_q[i]  <= resp_q[i-1];
         end
      end
   end

   assign out_valid_o = valid_q[RESP_LAT-1];
   assign out_resp_o  = resp_q[RESP_LAT-1];

endmodule

// File: rtl/cv32e40p_obi_data_responder.sv
// Data-side OBI responder: word RAM, fixed-latency in-order responses, outstanding limit.
// Define CV32E40P_OBI_RANDOM_GNT_EN for LFSR grant stalls plus a request-stability assertion.
module cv32e40p_obi_data_responder
   import cv32e40p_obi_pkg::*;
#(
   parameter int unsigned DATA_ADDR_MEM_WIDTH = 13,
   parameter int unsigned RESP_LAT            = 1,
   parameter int unsigned MAX_OUTSTANDING     = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      data_req_i,
   output logic                      data_gnt_o,
   input  logic [31:0]               data_addr_i,
   input  logic                      data_we_i,
   input  logic [OBI_BE_WIDTH-1:0]   data_be_i,
   input  logic [OBI_DATA_WIDTH-1:0] data_wdata_i,
   output logic                      data_rvalid_o,
   output logic [OBI_DATA_WIDTH-1:0] data_rdata_o,
   output logic                      data_err_o
);

   localparam int unsigned IdxW  = DATA_ADDR_MEM_WIDTH - 2;
   localparam int unsigned Depth = 2 ** IdxW;
   localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING + 1);

   logic [OBI_DATA_WIDTH-1:0] mem_q [Depth];
   logic [CntW-1:0]           cnt_q, cnt_d, cnt_eff;
   logic [IdxW-1:0]           word_idx;
   logic                      addr_err, accept, room, rnd_ok;
   logic                      out_valid;
   obi_resp_t                 resp_in, out_resp;

   assign word_idx = data_addr_i[DATA_ADDR_MEM_WIDTH-1:2];
   assign addr_err = (data_addr_i >> DATA_ADDR_MEM_WIDTH) != '0;

   // A response retiring this cycle frees its slot, so MAX_OUTSTANDING == RESP_LAT
   // sustains one accept per cycle.
   assign cnt_eff = (out_valid && (cnt_q != '0)) ? cnt_q - CntW'(1) : cnt_q;
   assign room    = cnt_eff < CntW'(MAX_OUTSTANDING);

   assign data_gnt_o = data_req_i && !rst_i && room && rnd_ok;
   assign accept     = data_req_i && data_gnt_o;

`ifdef CV32E40P_OBI_RANDOM_GNT_EN
   logic [15:0] lfsr_q, lfsr_d;

   assign lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
   assign rnd_ok = lfsr_q[0];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   property p_req_stable;
      @(posedge clk_i) disable iff (rst_i)
         (data_req_i && !data_gnt_o) |=>
            (data_req_i && $stable(data_addr_i) && $stable(data_we_i) &&
             $stable(data_be_i) && $stable(data_wdata_i));
   endproperty

   a_req_stable: assert property (p_req_stable);
`else
   assign rnd_ok = 1'b1;
`endif

   always_comb begin
      cnt_d = cnt_q;
      case ({accept, out_valid})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Memory contents survive reset; writes commit at the accept edge.
   always_ff @(posedge clk_i) begin
      if (accept && data_we_i && !addr_err) begin
         for (int b = 0; b < OBI_BE_WIDTH; b++) begin
            if (data_be_i[b]) begin
               mem_q[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      resp_in     = '0;
      resp_in.err = addr_err;
      if (!addr_err && !data_we_i) begin
         resp_in.rdata = mem_q[word_idx];
      end
   end

   cv32e40p_obi_resp_delay #(
      .RESP_LAT (RESP_LAT)
   ) u_resp_delay (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (accept),
      .in_resp_i   (resp_in),
      .out_valid_o (out_valid),
      .out_resp_o  (out_resp)
   );

   assign data_rvalid_o = out_valid;
   assign data_rdata_o  = out_valid ? out_resp.rdata : '0;
   assign data_err_o    = out_valid && out_resp.err;

endmodule

// File: tb/tb_cv32e40p_obi_data_responder.sv
// Scoreboard bench: dut0 uses RESP_LAT=1/MAX=2, dut1 uses RESP_LAT=3/MAX=2.
module tb_cv32e40p_obi_data_responder;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst    [2];
   logic        req    [2];
   logic        gnt    [2];
   logic [31:0] addr   [2];
   logic        we     [2];
   logic [3:0]  be     [2];
   logic [31:0] wdata  [2];
   logic        rvalid [2];
   logic [31:0] rdata  [2];
   logic        err    [2];

   int          cyc = 0;
   int          n_chk = 0;
   int          n_err = 0;
   int          stalls = 0;
   int          rv_cnt [2] = '{0, 0};
   exp_t        q0 [$];
   exp_t        q1 [$];
   bit          gnt_log [$];
   logic [31:0] mdl [2][2048];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cv32e40p_obi_data_responder #(
      .DATA_ADDR_MEM_WIDTH (13),
      .RESP_LAT            (1),
      .MAX_OUTSTANDING     (2)
   ) u_dut0 (
      .clk_i         (clk),
      .rst_i         (rst[0]),
      .data_req_i    (req[0]),
      .data_gnt_o    (gnt[0]),
      .data_addr_i   (addr[0]),
      .data_we_i     (we[0]),
      .data_be_i     (be[0]),
      .data_wdata_i  (wdata[0]),
      .data_rvalid_o (rvalid[0]),
      .data_rdata_o  (rdata[0]),
      .data_err_o    (err[0])
   );

   cv32e40p_obi_data_responder #(
      .DATA_ADDR_MEM_WIDTH (13),
      .RESP_LAT            (3),
      .MAX_OUTSTANDING     (2)
   ) u_dut1 (
      .clk_i         (clk),
      .rst_i         (rst[1]),
      .data_req_i    (req[1]),
      .data_gnt_o    (gnt[1]),
      .data_addr_i   (addr[1]),
      .data_we_i     (we[1]),
      .data_be_i     (be[1]),
      .data_wdata_i  (wdata[1]),
      .data_rvalid_o (rvalid[1]),
      .data_rdata_o  (rdata[1]),
      .data_err_o    (err[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expectation per rvalid, checks payload and arrival cycle.
   always @(negedge clk) begin : monitor
      exp_t e;
      bit   have;
      for (int d = 0; d < 2; d++) begin
         if (rvalid[d] === 1'b1) begin
            rv_cnt[d]++;
            have = 1'b0;
            if (d == 0 && q0.size() > 0) begin
               e = q0.pop_front();
               have = 1'b1;
            end else if (d == 1 && q1.size() > 0) begin
               e = q1.pop_front();
               have = 1'b1;
            end
            if (!have) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_rvalid dut%0d: got rvalid=1, expected none (cycle %0d)",
                        d, cyc);
            end else begin
               check($sformatf("rdata dut%0d", d), rdata[d], e.rdata);
               check($sformatf("err dut%0d", d), {31'b0, err[d]}, {31'b0, e.err});
               check($sformatf("latency dut%0d", d), 32'(cyc), 32'(e.due));
            end
         end
      end
   end

   // Called at posedge+1; leaves req high after the accept so calls can run back to back.
   task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee,
                       input bit use_mdl);
      bit          done = 1'b0;
      bit          bad;
      logic [10:0] idx;
      exp_t        e;
      req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
      idx = a[12:2];
      bad = (a[31:13] != '0);
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         if (d == 1) gnt_log.push_back(gnt[1] === 1'b1);
         if (gnt[d] !== 1'b1) begin
            if (d == 0) stalls++;
         end else begin
            done = 1'b1;
            if (use_mdl) begin
               e.err   = bad;
               e.rdata = (bad || w) ? 32'h0 : mdl[d][idx];
            end else begin
               e.err   = ee;
               e.rdata = er;
            end
            if (!bad && w) begin
               for (int k = 0; k < 4; k++) begin
                  if (b[k]) mdl[d][idx][8*k +: 8] = wd[8*k +: 8];
               end
            end
            e.due = cyc + ((d == 0) ? 1 : 3);
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         n_chk++;
         n_err++;
         $display("FAIL gnt_timeout dut%0d: got no grant, expected one within 64 cycles", d);
         req[d] = 1'b0;
      end
   endtask

   task automatic idle(input int d, input int n);
      req[d] = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input int d);
      req[d] = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) break;
         @(posedge clk);
         #1;
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not reach the summary in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int          base;
      logic [31:0] r, a;
      logic [5:0]  pat;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0;
         addr[d] = '0; be[d] = '0; wdata[d] = '0;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset gnt dut%0d", d), {31'b0, gnt[d]}, 32'h0);
         check($sformatf("reset rvalid dut%0d", d), {31'b0, rvalid[d]}, 32'h0);
         check($sformatf("reset rdata dut%0d", d), rdata[d], 32'h0);
         check($sformatf("reset err dut%0d", d), {31'b0, err[d]}, 32'h0);
         req[d] = 1'b1;
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("gnt held in reset dut%0d", d), {31'b0, gnt[d]}, 32'h0);
         req[d] = 1'b0;
      end
      @(posedge clk);
      #1;
      rst[0] = 1'b0;
      rst[1] = 1'b0;

      // Write then read the same word back to back.
      xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
      xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
      idle(0, 3);

      // Partial byte-enable write.
      xfer(0, 1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0, 1'b0, 1'b0);
      xfer(0, 1'b1, 32'h20, 4'h5, 32'hAABBCCDD, 32'h0, 1'b0, 1'b0);
      xfer(0, 1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB33DD, 1'b0, 1'b0);
      xfer(0, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
      xfer(0, 1'b0, 32'h20, 4'h0, 32'h0, 32'h11BB33DD, 1'b0, 1'b0);
      idle(0, 3);

      // Out-of-range addresses error out and leave word 0 untouched.
      xfer(0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
      xfer(0, 1'b0, 32'h2000, 4'hF, 32'h0, 32'h0, 1'b1, 1'b0);
      xfer(0, 1'b1, 32'h2000, 4'hF, 32'h12345678, 32'h0, 1'b1, 1'b0);
      xfer(0, 1'b0, 32'h8000_0010, 4'hF, 32'h0, 32'h0, 1'b1, 1'b0);
      xfer(0, 1'b0, 32'h0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);
      drain(0);

      // Longer latency: preload, then six held reads.
      xfer(1, 1'b1, 32'h40, 4'hF, 32'h5A5A1234, 32'h0, 1'b0, 1'b0);
      xfer(1, 1'b1, 32'h44, 4'hF, 32'h01010101, 32'h0, 1'b0, 1'b0);
      xfer(1, 1'b1, 32'h48, 4'hF, 32'hF0F0F0F0, 32'h0, 1'b0, 1'b0);
      drain(1);
      gnt_log.delete();
      xfer(1, 1'b0, 32'h40, 4'hF, 32'h0, 32'h5A5A1234, 1'b0, 1'b0);
      xfer(1, 1'b0, 32'h44, 4'hF, 32'h0, 32'h01010101, 1'b0, 1'b0);
      xfer(1, 1'b0, 32'h48, 4'hF, 32'h0, 32'hF0F0F0F0, 1'b0, 1'b0);
      xfer(1, 1'b0, 32'h40, 4'hF, 32'h0, 32'h5A5A1234, 1'b0, 1'b0);
      xfer(1, 1'b0, 32'h44, 4'hF, 32'h0, 32'h01010101, 1'b0, 1'b0);
      xfer(1, 1'b0, 32'h48, 4'hF, 32'h0, 32'hF0F0F0F0, 1'b0, 1'b0);
`ifndef CV32E40P_OBI_RANDOM_GNT_EN
      pat = '0;
      for (int i = 0; i < 6 && i < gnt_log.size(); i++) pat[5-i] = gnt_log[i];
      check("gnt pattern dut1", {26'b0, pat}, {26'b0, 6'b110110});
`endif
      drain(1);

      // Reset with two reads in flight: both responses are dropped.
      xfer(1, 1'b0, 32'h44, 4'hF, 32'h0, 32'h01010101, 1'b0, 1'b0);
      xfer(1, 1'b0, 32'h48, 4'hF, 32'h0, 32'hF0F0F0F0, 1'b0, 1'b0);
      rst[1] = 1'b1;
      q1.delete();
      base = rv_cnt[1];
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("gnt during reset dut1", {31'b0, gnt[1]}, 32'h0);
         check("rvalid during reset dut1", {31'b0, rvalid[1]}, 32'h0);
         @(posedge clk);
         #1;
      end
      rst[1] = 1'b0;
      idle(1, 8);
      check("rvalid count after reset dut1", 32'(rv_cnt[1] - base), 32'h0);
      xfer(1, 1'b0, 32'h40, 4'hF, 32'h0, 32'h5A5A1234, 1'b0, 1'b0);
      drain(1);

      // Random traffic on dut0 against the reference model.
      for (int k = 0; k < 16; k++) begin
         xfer(0, 1'b1, 32'h100 + 32'(4 * k), 4'hF, 32'h1000_0000 + 32'(k), 32'h0, 1'b0, 1'b1);
      end
      drain(0);
      stalls = 0;
      for (int n = 0; n < 1000; n++) begin
         r = $urandom;
         a = 32'h100 + {26'b0, r[4:1], 2'b00};
         if (r[8:5] == 4'h0) a = a | (32'h2000 << r[10:9]);
         xfer(0, r[0], a, r[14:11], $urandom, 32'h0, 1'b0, 1'b1);
         if (r[15]) idle(0, 1);
      end
      drain(0);
`ifdef CV32E40P_OBI_RANDOM_GNT_EN
      check("grant stalls seen", {31'b0, (stalls != 0)}, 32'h1);
`else
      check("grant stalls", 32'(stalls), 32'h0);
`endif
      check("dut0 queue empty", 32'(q0.size()), 32'h0);
      check("dut1 queue empty", 32'(q1.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
